// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared codes, states and helpers for the MEM stage
package mem_access_unit_pkg;

    localparam logic [1:0]  MSIZE_BYTE = 2'b00;
    localparam logic [1:0]  MSIZE_HALF = 2'b01;
    localparam logic [1:0]  MSIZE_WORD = 2'b10;
    localparam logic        RST_ENABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mau_state_t;

    // Size code 2'b11 is treated as a word access.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MSIZE_BYTE: is_aligned = 1'b1;
            MSIZE_HALF: is_aligned = ~off[0];
            default:    is_aligned = (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// rtl/mem_access_unit_lane_align.sv - mem_lane_align: byte enables, store lane replication, load extract/extend
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NB     = DATA_W / 8,
    parameter int OFF_W  = $clog2(NB)
) (
    input  logic [1:0]        i_msize,
    input  logic              i_msign,
    input  logic [OFF_W-1:0]  i_off,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [NB-1:0]     o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] w_shift;

    always_comb begin
        w_shift = i_rdata >> {i_off, 3'b000};
        o_be    = '1;
        o_wdata = i_wdata;
        o_rdata = w_shift;
        case (i_msize)
            MSIZE_BYTE: begin
                o_be = NB'(1) << i_off;
                for (int i = 0; i < NB; i++) o_wdata[8*i +: 8] = i_wdata[7:0];
                o_rdata = {{(DATA_W-8){i_msign & w_shift[7]}}, w_shift[7:0]};
            end
            MSIZE_HALF: begin
                o_be = NB'(3) << i_off;
                for (int i = 0; i < NB/2; i++) o_wdata[16*i +: 16] = i_wdata[15:0];
                o_rdata = {{(DATA_W-16){i_msign & w_shift[15]}}, w_shift[15:0]};
            end
            default: begin
                o_be = '1;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM pipeline stage with mem/periph req/ack bus and WB register
// Optional watchdog abort and timeout_o port enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PERIPH_BIT = 30,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic                  we_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  mre_i,
    input  logic                  mwe_i,
    input  logic [1:0]            msize_i,
    input  logic                  msign_i,
    input  logic [ADDR_W-1:0]     maddr_i,
    input  logic [DATA_W-1:0]     mwdata_i,
    output logic                  m_req_o,
    output logic                  p_req_o,
    output logic                  mp_we_o,
    output logic [DATA_W/8-1:0]   mp_be_o,
    output logic [ADDR_W-1:0]     mp_addr_o,
    output logic [DATA_W-1:0]     mp_wdata_o,
    input  logic [DATA_W-1:0]     m_rdata_i,
    input  logic                  m_ack_i,
    input  logic [DATA_W-1:0]     p_rdata_i,
    input  logic                  p_ack_i,
    output logic                  stall_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic                  we_o,
    output logic [DATA_W-1:0]     wdata_o,
`ifdef MEM_TIMEOUT_EN
    output logic                  timeout_o,
`endif
    output logic                  misalign_o
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT must be at least 1");
    end

    mau_state_t r_state, w_next_state;

    logic                   r_target, r_wr, r_msign;
    logic [1:0]             r_msize;
    logic [OFF_W-1:0]       r_off;
    logic [NB-1:0]          r_be;
    logic [ADDR_W-1:OFF_W]  r_addr_hi;
    logic [DATA_W-1:0]      r_wdata;
    logic [REG_ADDR_W-1:0]  r_waddr;

    logic                   w_busy, w_is_mem, w_sel_ack;
    logic                   w_accept, w_misal, w_done, w_abort;
    logic [1:0]             w_size;
    logic                   w_sign;
    logic [OFF_W-1:0]       w_off;
    logic [NB-1:0]          w_be;
    logic [DATA_W-1:0]      w_lane_wdata, w_rdata, w_rdata_ext;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    assign timeout_o = r_timeout;
`endif

    assign w_busy    = (r_state == ST_BUSY);
    assign w_is_mem  = mre_i | mwe_i;
    assign w_sel_ack = r_target ? p_ack_i : m_ack_i;
    assign w_rdata   = r_target ? p_rdata_i : m_rdata_i;

    // One aligner serves both directions: live inputs when accepting, latched fields while busy.
    assign w_size = w_busy ? r_msize : msize_i;
    assign w_sign = w_busy ? r_msign : msign_i;
    assign w_off  = w_busy ? r_off   : maddr_i[OFF_W-1:0];

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_msize (w_size),
        .i_msign (w_sign),
        .i_off   (w_off),
        .i_wdata (mwdata_i),
        .i_rdata (w_rdata),
        .o_be    (w_be),
        .o_wdata (w_lane_wdata),
        .o_rdata (w_rdata_ext)
    );

    assign m_req_o    = w_busy & ~r_target;
    assign p_req_o    = w_busy & r_target;
    assign mp_we_o    = w_busy & r_wr;
    assign mp_be_o    = w_busy ? r_be : '0;
    assign mp_addr_o  = w_busy ? {r_addr_hi, {OFF_W{1'b0}}} : '0;
    assign mp_wdata_o = w_busy ? r_wdata : '0;
    assign stall_o    = w_busy & ~w_sel_ack;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) r_state <= ST_IDLE;
        else                   r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_misal      = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid_i && w_is_mem) begin
                    if (is_aligned(msize_i, maddr_i[1:0])) begin
                        w_accept     = 1'b1;
                        w_next_state = ST_BUSY;
                    end else begin
                        w_misal = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (w_sel_ack) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_IDLE;
                end
`endif
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            we_o       <= 1'b0;
            waddr_o    <= '0;
            wdata_o    <= DATA_W'(ZERO_WORD);
            misalign_o <= 1'b0;
            r_target   <= 1'b0;
            r_wr       <= 1'b0;
            r_msign    <= 1'b0;
            r_msize    <= MSIZE_BYTE;
            r_off      <= '0;
            r_be       <= '0;
            r_addr_hi  <= '0;
            r_wdata    <= '0;
            r_waddr    <= '0;
`ifdef MEM_TIMEOUT_EN
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            we_o       <= 1'b0;
            misalign_o <= w_misal;
            if (r_state == ST_IDLE && valid_i && !w_is_mem) begin
                we_o    <= we_i;
                waddr_o <= waddr_i;
                wdata_o <= wdata_i;
            end
            if (w_accept) begin
                r_target  <= maddr_i[PERIPH_BIT];
                r_wr      <= mwe_i;
                r_msign   <= msign_i;
                r_msize   <= msize_i;
                r_off     <= maddr_i[OFF_W-1:0];
                r_be      <= w_be;
                r_addr_hi <= maddr_i[ADDR_W-1:OFF_W];
                r_wdata   <= w_lane_wdata;
                r_waddr   <= waddr_i;
            end
            if (w_done && !r_wr) begin
                we_o    <= 1'b1;
                waddr_o <= r_waddr;
                wdata_o <= w_rdata_ext;
            end
`ifdef MEM_TIMEOUT_EN
            r_cnt     <= w_busy ? r_cnt + CNT_W'(1) : '0;
            r_timeout <= w_abort;
            if (w_abort && !r_wr) begin
                we_o    <= 1'b1;
                waddr_o <= r_waddr;
                wdata_o <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, we_i, mre_i, mwe_i, msign_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i, maddr_i, mwdata_i, m_rdata_i, p_rdata_i;
    logic [1:0]  msize_i;
    logic        m_ack_i, p_ack_i;
    logic        m_req_o, p_req_o, mp_we_o, stall_o, we_o, misalign_o;
    logic [3:0]  mp_be_o;
    logic [31:0] mp_addr_o, mp_wdata_o, wdata_o;
    logic [4:0]  waddr_o;
`ifdef MEM_TIMEOUT_EN
    logic        timeout_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int n_req, n_stall;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .waddr_i(waddr_i), .we_i(we_i),
        .wdata_i(wdata_i), .mre_i(mre_i), .mwe_i(mwe_i), .msize_i(msize_i),
        .msign_i(msign_i), .maddr_i(maddr_i), .mwdata_i(mwdata_i),
        .m_req_o(m_req_o), .p_req_o(p_req_o), .mp_we_o(mp_we_o), .mp_be_o(mp_be_o),
        .mp_addr_o(mp_addr_o), .mp_wdata_o(mp_wdata_o), .m_rdata_i(m_rdata_i),
        .m_ack_i(m_ack_i), .p_rdata_i(p_rdata_i), .p_ack_i(p_ack_i),
        .stall_o(stall_o), .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o),
`ifdef MEM_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .misalign_o(misalign_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd_addr);
        valid_i = 1'b1; mre_i = rd; mwe_i = wr; msize_i = sz; msign_i = sg;
        maddr_i = addr; mwdata_i = sdata; waddr_i = rd_addr; we_i = rd;
        tick();
        valid_i = 1'b0; mre_i = 1'b0; mwe_i = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0; valid_i = 0; we_i = 0; mre_i = 0; mwe_i = 0; msign_i = 0;
        waddr_i = 0; wdata_i = 0; maddr_i = 0; mwdata_i = 0; msize_i = 0;
        m_rdata_i = 0; p_rdata_i = 0; m_ack_i = 0; p_ack_i = 0;
        tick(); tick();
        check("rst_we", {31'b0, we_o}, 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_waddr", {27'b0, waddr_o}, 32'd0);
        check("rst_reqs", {30'b0, m_req_o, p_req_o}, 32'd0);
        check("rst_be", {28'b0, mp_be_o}, 32'd0);
        check("rst_stall_mis", {30'b0, stall_o, misalign_o}, 32'd0);
        rst = 1'b1;
        tick();

        // ALU op, latency 1
        valid_i = 1; waddr_i = 5'd3; we_i = 1; wdata_i = 32'h1234;
        tick();
        valid_i = 0; we_i = 0;
        check("alu_we", {31'b0, we_o}, 32'd1);
        check("alu_waddr", {27'b0, waddr_o}, 32'd3);
        check("alu_wdata", wdata_o, 32'h1234);
        check("alu_stall", {31'b0, stall_o}, 32'd0);
        tick();
        check("idle_we", {31'b0, we_o}, 32'd0);

        // lb signed, two wait cycles, stray peripheral ack ignored
        issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0, 5'd5);
        check("lb_be", {28'b0, mp_be_o}, 32'h8);
        check("lb_addr", mp_addr_o, 32'h0);
        check("lb_preq", {31'b0, p_req_o}, 32'd0);
        n_req = 0; n_stall = 0;
        for (int c = 0; c < 3; c++) begin
            p_ack_i = (c == 0);
            m_ack_i = (c == 2);
            m_rdata_i = 32'h80FF_FF7F;
            #1;
            if (m_req_o) n_req++;
            if (stall_o) n_stall++;
            tick();
        end
        m_ack_i = 0; p_ack_i = 0;
        check("lb_req_cycles", n_req, 32'd3);
        check("lb_stall_cycles", n_stall, 32'd2);
        check("lb_req_drop", {31'b0, m_req_o}, 32'd0);
        check("lb_we", {31'b0, we_o}, 32'd1);
        check("lb_waddr", {27'b0, waddr_o}, 32'd5);
        check("lb_wdata", wdata_o, 32'hFFFF_FF80);

        // sh to peripheral
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h4000_0002, 32'h0000_ABCD, 5'd0);
        check("sh_preq", {31'b0, p_req_o}, 32'd1);
        check("sh_mreq", {31'b0, m_req_o}, 32'd0);
        check("sh_we", {31'b0, mp_we_o}, 32'd1);
        check("sh_be", {28'b0, mp_be_o}, 32'hC);
        check("sh_wdata", mp_wdata_o, 32'hABCD_ABCD);
        check("sh_addr", mp_addr_o, 32'h4000_0000);
        check("sh_stall", {31'b0, stall_o}, 32'd1);
        p_ack_i = 1; #1;
        check("sh_stall_ack", {31'b0, stall_o}, 32'd0);
        tick();
        p_ack_i = 0;
        check("sh_preq_drop", {31'b0, p_req_o}, 32'd0);
        check("sh_wb_we", {31'b0, we_o}, 32'd0);

        // misaligned lw
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 5'd7);
        check("mis_pulse", {31'b0, misalign_o}, 32'd1);
        check("mis_reqs", {30'b0, m_req_o, p_req_o}, 32'd0);
        check("mis_we", {31'b0, we_o}, 32'd0);
        tick();
        check("mis_pulse_end", {31'b0, misalign_o}, 32'd0);

        // lhu zero-extended, zero wait states
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 5'd9);
        check("lhu_be", {28'b0, mp_be_o}, 32'hC);
        m_rdata_i = 32'h9ABC_1234; m_ack_i = 1;
        tick();
        m_ack_i = 0;
        check("lhu_wdata", wdata_o, 32'h0000_9ABC);
        check("lhu_waddr", {27'b0, waddr_o}, 32'd9);

        // load and store together: store wins
        issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_0055, 5'd4);
        check("sb_we", {31'b0, mp_we_o}, 32'd1);
        check("sb_be", {28'b0, mp_be_o}, 32'h2);
        check("sb_wdata", mp_wdata_o, 32'h5555_5555);
        m_ack_i = 1;
        tick();
        m_ack_i = 0;
        check("sb_wb_we", {31'b0, we_o}, 32'd0);

        // reset while busy, later ack ignored
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 5'd2);
        check("rb_req", {31'b0, m_req_o}, 32'd1);
        rst = 0;
        tick();
        rst = 1;
        check("rb_reqs", {30'b0, m_req_o, p_req_o}, 32'd0);
        check("rb_stall", {31'b0, stall_o}, 32'd0);
        m_ack_i = 1; m_rdata_i = 32'hDEAD_BEEF;
        tick();
        m_ack_i = 0;
        check("rb_late_ack_we", {31'b0, we_o}, 32'd0);
        check("rb_late_ack_req", {31'b0, m_req_o}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0, 5'd6);
        n_req = 0;
        for (int c = 0; c < 10 && m_req_o; c++) begin
            n_req++;
            tick();
        end
        check("to_busy_cycles", n_req, 32'd4);
        check("to_pulse", {31'b0, timeout_o}, 32'd1);
        check("to_we", {31'b0, we_o}, 32'd1);
        check("to_wdata", wdata_o, 32'd0);
        tick();
        check("to_pulse_end", {31'b0, timeout_o}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
